// File: rtl/param_shift_register.sv
// Parameterised shift/rotate/load register with a multi-step IDLE/RUN/DONE sequencer.
// Optional parity output is enabled by defining PSR_PARITY_EN.
module param_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [2:0]       mode,
  input  logic             sin_left,
  input  logic             sin_right,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout_right,
  output logic             sout_left,
  output logic             busy,
`ifdef PSR_PARITY_EN
  output logic             parity,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;

  logic [2:0]       op_sel;
  logic [WIDTH-1:0] shr_v, shl_v, ror_v, rol_v, asr_v;
  logic [WIDTH-1:0] step_v;

  function automatic logic is_multi(input logic [2:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

  // Per-bit candidate networks; the end bits pick up serial inputs or wrap-around.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_v[gi] = sin_left;
        assign ror_v[gi] = q_q[0];
        assign asr_v[gi] = q_q[WIDTH-1];
      end else begin : g_mid_hi
        assign shr_v[gi] = q_q[gi+1];
        assign ror_v[gi] = q_q[gi+1];
        assign asr_v[gi] = q_q[gi+1];
      end
      if (gi == 0) begin : g_lsb
        assign shl_v[gi] = sin_right;
        assign rol_v[gi] = q_q[WIDTH-1];
      end else begin : g_mid_lo
        assign shl_v[gi] = q_q[gi-1];
        assign rol_v[gi] = q_q[gi-1];
      end
    end
  endgenerate

  // While running, the latched op drives the datapath instead of the live mode input.
  assign op_sel = (state_q == RUN) ? op_q : mode;

  always_comb begin
    step_v = q_q;
    case (op_sel)
      MODE_SHR:  step_v = shr_v;
      MODE_SHL:  step_v = shl_v;
      MODE_LOAD: step_v = pin;
      MODE_ROR:  step_v = ror_v;
      MODE_ROL:  step_v = rol_v;
      MODE_ASR:  step_v = asr_v;
      default:   step_v = q_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    op_d    = op_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start && is_multi(mode)) begin
            if (count != '0) begin
              op_d    = mode;
              rem_d   = count;
              state_d = RUN;
            end else begin
              state_d = DONE;
            end
          end else begin
            q_d = step_v;
          end
        end
        RUN: begin
          q_d   = step_v;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      op_q    <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign q          = q_q;
  assign sout_right = q_q[0];
  assign sout_left  = q_q[WIDTH-1];
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
`ifdef PSR_PARITY_EN
  assign parity     = ^q_q;
`endif

endmodule

// File: tb/tb_param_shift_register.sv
// Self-checking bench for param_shift_register (WIDTH=8, CNT_W=3): directed scenarios
// plus randomized traffic compared against an arithmetic reference model.
module tb_param_shift_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] mode;
  logic       sin_left;
  logic       sin_right;
  logic [7:0] pin;
  logic       start;
  logic [2:0] count;
  logic [7:0] q;
  logic       sout_right;
  logic       sout_left;
  logic       busy;
  logic       done;
`ifdef PSR_PARITY_EN
  logic       parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_q;
  int m_op;
  int m_steps;
  bit m_done;

  always #5 clk = ~clk;

  param_shift_register #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
    .sin_left(sin_left), .sin_right(sin_right), .pin(pin),
    .start(start), .count(count), .q(q),
    .sout_right(sout_right), .sout_left(sout_left), .busy(busy),
`ifdef PSR_PARITY_EN
    .parity(parity),
`endif
    .done(done)
  );

  function automatic int ref_op(input int op, input int v, input int sl, input int sr, input int p);
    int r;
    case (op)
      1: r = (v >> 1) | (sl << 7);
      2: r = ((v << 1) & 255) | sr;
      3: r = p;
      4: r = (v >> 1) | ((v & 1) << 7);
      5: r = ((v << 1) & 255) | (v >> 7);
      6: r = (v >> 1) | (v & 128);
      default: r = v;
    endcase
    return r & 255;
  endfunction

  task automatic model_reset();
    m_q = 0; m_op = 0; m_steps = 0; m_done = 0;
  endtask

  task automatic model_edge();
    if (!ena) return;
    if (m_done) begin
      m_done = 0;
    end else if (m_steps > 0) begin
      m_q = ref_op(m_op, m_q, sin_left, sin_right, 0);
      m_steps--;
      if (m_steps == 0) m_done = 1;
    end else if (start && (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
      m_op = mode;
      m_steps = count;
      if (count == 0) m_done = 1;
    end else begin
      m_q = ref_op(mode, m_q, sin_left, sin_right, pin);
    end
  endtask

  // advance model and DUT by one clock; leaves time at posedge+1
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    ena = 1; start = 0; mode = 3'b011; pin = v;
    tick();
    mode = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 0; ena = 0; mode = 0; sin_left = 0; sin_right = 0; pin = 0; start = 0; count = 0;
    model_reset();
    #3;
    n_checks++;
    if ({q, busy, done} !== 10'b0) begin
      n_fail++; $display("FAIL reset_initial q=%h busy=%b done=%b required 00/0/0", q, busy, done);
    end
    @(posedge clk); #1;
    rst_n = 1;
    load(8'hA5);
    n_checks++;
    if (q !== 8'hA5) begin n_fail++; $display("FAIL reset_preload q=%h required a5", q); end
    #3; rst_n = 0; #1;
    n_checks++;
    if ({q, busy, done, sout_left, sout_right} !== 12'b0) begin
      n_fail++; $display("FAIL reset_async q=%h busy=%b done=%b sl=%b sr=%b required all 0",
                         q, busy, done, sout_left, sout_right);
    end
    model_reset();
    #1; rst_n = 1;
    $display("reset: q=%h busy=%b done=%b", q, busy, done);
  endtask

  task automatic test_shift();
    load(8'h0D);
    n_checks++;
    if (q !== 8'h0D) begin n_fail++; $display("FAIL shift_load q=%h required 0d", q); end
    mode = 3'b001; sin_left = 1;
    tick();
    n_checks++;
    if (q !== 8'h86) begin n_fail++; $display("FAIL shift_r1 q=%h required 86", q); end
    tick();
    n_checks++;
    if ({q, sout_left, sout_right} !== {8'hC3, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL shift_r2 q=%h sl=%b sr=%b required c3/1/1", q, sout_left, sout_right);
    end
    mode = 3'b010; sin_right = 0;
    tick();
    n_checks++;
    if (q !== 8'h86) begin n_fail++; $display("FAIL shift_l q=%h required 86", q); end
    mode = 0;
    $display("shift: q=%h", q);
  endtask

  task automatic test_rotate();
    load(8'h81);
    mode = 3'b100; tick();
    n_checks++;
    if (q !== 8'hC0) begin n_fail++; $display("FAIL rot_r q=%h required c0", q); end
    mode = 3'b101; tick();
    n_checks++;
    if (q !== 8'h81) begin n_fail++; $display("FAIL rot_l q=%h required 81", q); end
    load(8'h90);
    mode = 3'b110; tick();
    n_checks++;
    if (q !== 8'hC8) begin n_fail++; $display("FAIL asr q=%h required c8", q); end
    mode = 3'b111; tick();
    n_checks++;
    if (q !== 8'hC8) begin n_fail++; $display("FAIL reserved_hold q=%h required c8", q); end
    mode = 0;
    $display("rotate: q=%h", q);
  endtask

  task automatic test_multi();
    logic [7:0] eq [5];
    bit eb [5];
    bit ed [5];
    eq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h08};
    eb = '{1, 1, 1, 1, 0};
    ed = '{0, 0, 0, 1, 0};
    load(8'h01);
    start = 1; mode = 3'b101; count = 3;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        start = 1'($urandom); mode = 3'($urandom); count = 3'($urandom); pin = 8'($urandom);
      end
      tick();
      n_checks++;
      if ({q, busy, done} !== {eq[i], eb[i], ed[i]}) begin
        n_fail++; $display("FAIL multi_step%0d q=%h busy=%b done=%b required %h/%b/%b",
                           i, q, busy, done, eq[i], eb[i], ed[i]);
      end
      mode = 0; start = 0;
    end
    $display("multi: q=%h busy=%b done=%b", q, busy, done);
  endtask

  task automatic test_zero_and_stall();
    bit got_done;
    load(8'h33);
    start = 1; mode = 3'b001; count = 0; sin_left = 1;
    tick();
    start = 0; mode = 0;
    n_checks++;
    if ({q, busy, done} !== {8'h33, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL zero_count q=%h busy=%b done=%b required 33/1/1", q, busy, done);
    end
    tick();
    n_checks++;
    if ({q, busy, done} !== {8'h33, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL zero_count_idle q=%h busy=%b done=%b required 33/0/0", q, busy, done);
    end
    load(8'h01);
    start = 1; mode = 3'b010; count = 5; sin_right = 1;
    tick();
    start = 0; mode = 3'b011;
    tick();
    ena = 0;
    for (int i = 0; i < 3; i++) begin
      mode = 3'($urandom); start = 1; pin = 8'($urandom);
      tick();
      n_checks++;
      if ({q, busy, done} !== {8'h03, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL stall%0d q=%h busy=%b done=%b required 03/1/0", i, q, busy, done);
      end
    end
    ena = 1; start = 0; mode = 0;
    got_done = 0;
    for (int i = 0; i < 10 && !got_done; i++) begin
      tick();
      n_checks++;
      if (q !== 8'(m_q)) begin
        n_fail++; $display("FAIL stall_resume q=%h required %h", q, 8'(m_q));
      end
      if (done) got_done = 1;
    end
    n_checks++;
    if (!got_done || q !== 8'h3F) begin
      n_fail++; $display("FAIL stall_complete done_seen=%b q=%h required 1/3f", got_done, q);
    end
    tick();
    $display("stall: q=%h busy=%b", q, busy);
  endtask

  task automatic test_reset_run();
    bit saw_done;
    load(8'h0D);
    start = 1; mode = 3'b100; count = 7;
    tick();
    start = 0;
    tick();
    tick();
    #3; rst_n = 0; #1;
    n_checks++;
    if ({q, busy, done} !== 10'b0) begin
      n_fail++; $display("FAIL reset_run q=%h busy=%b done=%b required 00/0/0", q, busy, done);
    end
    model_reset();
    #1; rst_n = 1;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) saw_done = 1;
    end
    n_checks++;
    if (saw_done) begin n_fail++; $display("FAIL reset_run_abort busy/done seen=1 required 0"); end
`ifdef PSR_PARITY_EN
    load(8'hC3);
    n_checks++;
    if (parity !== 1'b0) begin n_fail++; $display("FAIL parity_c3 parity=%b required 0", parity); end
    load(8'hC2);
    n_checks++;
    if (parity !== 1'b1) begin n_fail++; $display("FAIL parity_c2 parity=%b required 1", parity); end
`endif
    $display("reset_run: q=%h", q);
  endtask

  task automatic test_random();
    logic [7:0] mq;
    bit eb;
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      ena = (($urandom % 8) != 0);
      mode = 3'($urandom);
      start = (($urandom % 3) == 0);
      count = 3'($urandom);
      sin_left = 1'($urandom);
      sin_right = 1'($urandom);
      pin = 8'($urandom);
      tick();
      mq = 8'(m_q);
      eb = (m_steps > 0) || m_done;
      n_checks++;
      if ({q, busy, done, sout_left, sout_right} !== {mq, eb, m_done, mq[7], mq[0]}) begin
        n_fail++; errs++;
        $display("FAIL random%0d q=%h busy=%b done=%b required %h/%b/%b", i, q, busy, done, mq, eb, m_done);
      end
`ifdef PSR_PARITY_EN
      n_checks++;
      if (parity !== ^mq) begin n_fail++; $display("FAIL random_parity%0d parity=%b required %b", i, parity, ^mq); end
`endif
    end
    $display("random: 400 cycles, %0d errors", errs);
  endtask

  initial begin
    test_reset();
    test_shift();
    test_rotate();
    test_multi();
    test_zero_and_stall();
    test_reset_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_shift_register.md
PARAM_SHIFT_REGISTER -- requirements
Module: param_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 Parameter CNT_W, default 3, width of the multi-step shift count.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; clock port clk, reset port rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ena  in  1  global enable; 0 freezes all state.
REQ-007 mode  in  3  operation select (see Function).
REQ-008 sin_left  in  1  serial bit entering MSB on shift right.
REQ-009 sin_right  in  1  serial bit entering LSB on shift left.
REQ-010 pin  in  WIDTH  parallel load data.
REQ-011 start  in  1  request multi-step operation of count steps.
REQ-012 count  in  CNT_W  number of steps for a multi-step operation.
REQ-013 q  out  WIDTH  register contents.
REQ-014 sout_right  out  1  q[0]; sout_left  out  1  q[WIDTH-1].
REQ-015 busy  out  1  high in states RUN and DONE; done  out  1  high in state DONE only.

Function
REQ-016 mode encoding SHALL be: 000 hold; 001 shift right, MSB<=sin_left; 010 shift left, LSB<=sin_right; 011 load q<=pin; 100 rotate right; 101 rotate left; 110 arithmetic shift right (MSB kept); 111 reserved = hold.
REQ-017 FSM states SHALL be IDLE, RUN, DONE; IDLE after reset.
REQ-018 In IDLE with ena=1 and start=0, q SHALL perform one mode operation per rising edge.
REQ-019 In IDLE, start=1, mode in {001,010,100,101,110}, count!=0: latch op<=mode, rem<=count, q unchanged, go to RUN.
REQ-020 In IDLE, start=1, count=0, shift/rotate mode: q unchanged, go directly to DONE.
REQ-021 start=1 with mode in {000,011,111} SHALL be ignored as a request; mode executes as in REQ-018.
REQ-022 In RUN each edge SHALL apply latched op once, rem<=rem-1; when rem==1, go to DONE.
REQ-023 In RUN, sin_left/sin_right SHALL be sampled live on each step; mode, start, count, pin ignored.
REQ-024 DONE SHALL last exactly one enabled cycle, hold q, ignore all commands, then return to IDLE.
REQ-025 Total latency start-accept to done: 1 + count edges; busy high for count+1 cycles.
REQ-026 ena=0 SHALL freeze q, state and rem; outputs hold; operation resumes where stalled.
REQ-027 sout_right, sout_left, busy, done SHALL be combinational decodes of registered state; no input-to-output paths.

Reset
REQ-028 rst_n=0 SHALL immediately set q=0, rem=0, state=IDLE; busy=0, done=0, sout_*=0, independent of clk and ena.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no done pulse.

Configuration
REQ-030 Macro PSR_PARITY_EN defined: extra output port parity (1 bit) = XOR reduction of q, valid in all states, 0 in reset.
REQ-031 Macro PSR_PARITY_EN undefined: port parity absent; all other behaviour identical.

Verification (WIDTH=8, CNT_W=3)
REQ-032 rst_n=0 asynchronously mid-cycle -> q=0x00, busy=0, done=0 before the next clk edge.
REQ-033 mode=011 pin=0x0D, then mode=001 sin_left=1 two edges -> q=0x0D, 0x86, 0xC3.
REQ-034 load 0x81, mode=100 one edge -> 0xC0; mode=101 one edge -> 0x81; load 0x90, mode=110 -> 0xC8.
REQ-035 load 0x01, start=1 mode=101 count=3 -> busy 4 cycles, q 0x02,0x04,0x08, done one cycle with q=0x08; mode toggles during RUN ignored.
REQ-036 start with count=0 -> done next cycle, q unchanged; ena=0 mid-RUN for 3 cycles -> q, rem frozen, completes after release.
REQ-037 rst_n pulsed low during RUN -> q=0x00, IDLE, no done pulse; with PSR_PARITY_EN, q=0xC3 -> parity=0.
